tdm_demux16: RTL
================

Name: tdm_demux16

Overview:
- 1-to-16 time-division demultiplexer; the counterpart of the team's 16:1 channel mux.
- Accepts a serial stream with one bit per slot, qualified by din_valid. frame_sync marks slot 0.
- Steers each bit into its channel position and publishes the 16 channel bits in parallel once per complete frame.
- Sits on the receive side of the TDM link, feeding per-channel logic.

Parameters:
- NCH, 16, number of channels/slots per frame (power of two)
- SW, 4, slot index width, equal to log2(NCH)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- din  input  1  serial data bit for the current slot
- din_valid  input  1  din/frame_sync qualifier; beat accepted when high
- frame_sync  input  1  high on the beat carrying slot 0
- Out  output  NCH  parallel channel word; Out[k] is slot k of last complete frame
- out_valid  output  1  one-cycle pulse when Out updates
- slot  output  SW  index of the slot the next accepted beat will fill
- locked  output  1  high while in RUN state
- sync_err  output  1  one-cycle pulse on frame alignment violation

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: Out=0, out_valid=0, slot=0, locked=0, sync_err=0, internal shadow register=0, state HUNT.
- A beat is a rising edge with din_valid=1. With din_valid=0, all state, slot, shadow and Out hold, and the pulses deassert.
- HUNT state:
  - Beat with frame_sync=0: discarded, no error.
  - Beat with frame_sync=1: shadow[0]<=din, slot<=1, go RUN.
- RUN state, beat at slot s != 0:
  - frame_sync=0: shadow[s]<=din, slot<=s+1.
  - frame_sync=1 (early sync): sync_err pulses next cycle. The partial frame is discarded and shadow cleared. The beat is taken as slot 0: shadow[0]<=din, slot<=1. Stay in RUN. Out is unchanged.
- RUN state, beat at slot 0:
  - frame_sync must be 1. It then behaves as a normal slot-0 write.
  - frame_sync=0 (missing sync): sync_err pulses, the bit is discarded, slot<=0, go HUNT, locked falls next cycle.
- Frame completion, beat at slot NCH-1 (frame_sync=0):
  - Out<={din, shadow[NCH-2:0]}, out_valid=1 for exactly one cycle.
  - slot wraps to 0.
  - Latency is 1 clock from the accepting edge of the last bit to Out/out_valid visible.
- frame_sync=1 on the slot NCH-1 beat is an early sync (rule above). No output is produced for that frame.
- Back-to-back frames with din_valid held high give one out_valid pulse every NCH cycles, with no bubbles.
- Out holds the last complete frame indefinitely. It changes only with out_valid.
- rst asserted mid-frame: the next edge applies reset values, the partial frame is lost, and the block returns to HUNT.
- slot arithmetic is modulo NCH (natural SW-bit wrap).
- locked=1 exactly while in RUN state.

Decomposition:
- Shared package holds:
  - constants NCH=16 and SW=4
  - state encoding HUNT=1'b0, RUN=1'b1
- One sub-module is natural: tdm_slot_counter, a modulo-NCH counter with enable (accepted beat), sync load-to-1 (slot-0 beat) and clear (rst/HUNT entry). It outputs slot and a last-slot flag.
- The remaining FSM, shadow register and output register stay in tdm_demux16.

Test Plan:
- Reset then idle: rst high 2 cycles, din_valid=0 for 20 cycles -> Out=0x0000, out_valid=0, locked=0, slot=0 throughout.
- Single frame: sync on first beat, then 16 beats of din encoding 0xA5C3 (bit k = slot k) -> Out=0xA5C3 one cycle after the 16th beat, out_valid high exactly 1 cycle, locked=1, slot=0.
- Gapped input: same 0xA5C3 frame with din_valid low on every other cycle -> identical Out. out_valid comes 1 cycle after the last accepted beat. slot holds during gaps.
- Back-to-back: frames 0x0001, 0x8000, 0xFFFF with continuous din_valid -> out_valid every 16 cycles, Out sequence as sent, sync_err never asserts.
- Early sync: frame_sync=1 at slot 7, then 16 beats encoding 0x1234 -> sync_err pulse 1 cycle, no out_valid for the broken frame, then Out=0x1234.
- Missing sync and reset mid-frame:
  - frame_sync=0 at slot 0 -> sync_err pulse, locked=0, subsequent beats ignored until the next sync.
  - rst at slot 9 -> Out keeps reset value 0x0000, state HUNT, slot=0.

Source files
------------

// File: rtl/tdm_demux16_pkg.sv
// tdm_demux16_pkg: shared constants and FSM encoding for the 1-to-16 TDM demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdm_demux16_pkg;

    localparam int NCH = 16;    // channels (slots) per frame, power of two
    localparam int SW  = 4;     // slot index width, log2(NCH)

    // HUNT: waiting for frame_sync; RUN: aligned and filling slots
    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_demux16_slot_counter.sv
// tdm_slot_counter: modulo-NCH slot index with enable, load-to-1 and clear.
// Latency: slot updates on the edge that sees the control input.
// Backpressure: none; the counter only moves when en/load1/clr is asserted.
// Ports: clk, rst (sync, active-high), clr (force 0), load1 (slot-0 beat, next slot is 1),
//        en (advance by one), slot (current index), last (slot == NCH-1).
module tdm_slot_counter
    import tdm_demux16_pkg::*;
#(
    parameter int P_NCH = NCH,
    parameter int P_SW  = SW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            load1,
    input  logic            en,
    output logic [P_SW-1:0] slot,
    output logic            last
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            slot <= '0;
        end else if (load1) begin
            slot <= P_SW'(1);
        end else if (en) begin
            // natural P_SW-bit wrap gives modulo-NCH arithmetic
            slot <= slot + P_SW'(1);
        end
    end

    assign last = (slot == P_SW'(P_NCH - 1));

endmodule

// File: rtl/tdm_demux16.sv
// tdm_demux16: 1-to-16 TDM demultiplexer, steers one serial bit per slot into a parallel word.
// Latency: Out/out_valid visible 1 clock after the edge accepting the last slot of a frame.
// Backpressure: none; din_valid low simply stalls everything (state, slot, shadow, Out hold).
// Ports: clk, rst (sync, active-high), din/din_valid/frame_sync (serial input, frame_sync marks
//        slot 0), Out/out_valid (last complete frame + update pulse), slot (next slot to fill),
//        locked (in RUN), sync_err (alignment violation pulse).
module tdm_demux16
    import tdm_demux16_pkg::*;
#(
    parameter int P_NCH = NCH,
    parameter int P_SW  = SW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [P_NCH-1:0] Out,
    output logic             out_valid,
    output logic [P_SW-1:0]  slot,
    output logic             locked,
    output logic             sync_err
);

    state_t           state;
    state_t           state_nxt;
    logic [P_NCH-1:0] shadow;
    logic             last;

    logic cnt_clr;
    logic cnt_load1;
    logic cnt_en;
    logic sh_load0;     // start a new frame: clear shadow, write slot 0
    logic sh_wr;        // write din into shadow[slot]
    logic frame_done;   // this beat completes a frame
    logic err;          // this beat violates frame alignment

    tdm_slot_counter #(
        .P_NCH (P_NCH),
        .P_SW  (P_SW)
    ) u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .load1 (cnt_load1),
        .en    (cnt_en),
        .slot  (slot),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        cnt_load1  = 1'b0;
        cnt_en     = 1'b0;
        sh_load0   = 1'b0;
        sh_wr      = 1'b0;
        frame_done = 1'b0;
        err        = 1'b0;
        if (din_valid) begin
            case (state)
                HUNT: begin
                    // non-sync beats are discarded silently while hunting
                    if (frame_sync) begin
                        cnt_load1 = 1'b1;
                        sh_load0  = 1'b1;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (frame_sync) begin
                        // sync at slot 0 is normal; anywhere else is an early sync that
                        // drops the partial frame and restarts alignment on this beat
                        cnt_load1 = 1'b1;
                        sh_load0  = 1'b1;
                        err       = (slot != '0);
                    end else if (slot == '0) begin
                        // missing sync: alignment lost, bit discarded
                        err       = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = HUNT;
                    end else begin
                        cnt_en     = 1'b1;
                        sh_wr      = 1'b1;
                        frame_done = last;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (sh_load0) begin
            shadow <= {{(P_NCH-1){1'b0}}, din};
        end else if (sh_wr) begin
            shadow[slot] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Out       <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            out_valid <= frame_done;
            sync_err  <= err;
            // the last bit bypasses the shadow so the word is ready one clock after it
            if (frame_done) begin
                Out <= {din, shadow[P_NCH-2:0]};
            end
        end
    end

    assign locked = (state == RUN);

endmodule
